// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for the FIFO access arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned MAX_WR     = 8;
   localparam int unsigned PTR_MAX_W  = 3;

   // One-hot grant: first request at or above ptr, wrapping at n.
   function automatic logic [MAX_WR-1:0] rr_pick(input logic [MAX_WR-1:0]    req,
                                                 input logic [PTR_MAX_W-1:0] ptr,
                                                 input int unsigned          n);
      logic [MAX_WR-1:0]    gnt;
      logic [PTR_MAX_W-1:0] idx;
      gnt = '0;
      for (int unsigned k = 0; k < MAX_WR; k++) begin
         idx = PTR_MAX_W'((32'(ptr) + k) % n);
         if ((k < n) && (gnt == '0) && req[idx]) gnt[idx] = 1'b1;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// Producer/consumer side of the FIFO access arbiter: write ports and the read port.
interface fifo_access_arbiter_if #(
   parameter int unsigned NUM_WR = 4,
   parameter int unsigned DATA_W = 8
);
   logic [NUM_WR-1:0]        wr_valid;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_WR-1:0]        wr_ready;
   logic                     rd_req;
   logic                     rd_ready;
   logic [DATA_W-1:0]        rd_data;
   logic                     rd_data_valid;

   modport master (
      output wr_valid, wr_data, rd_req,
      input  wr_ready, rd_ready, rd_data, rd_data_valid
   );

   modport slave (
      input  wr_valid, wr_data, rd_req,
      output wr_ready, rd_ready, rd_data, rd_data_valid
   );
endinterface

// File: rtl/fifo_access_arbiter_rr_arbiter.sv
// Round-robin writer selection; the pointer moves past a port only when its grant is used.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_WR = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_WR-1:0] req,
   input  logic              advance,
   output logic [NUM_WR-1:0] gnt
);
   localparam int unsigned PTR_W = $clog2(NUM_WR);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] ptr_next;

   always_comb begin
      gnt      = NUM_WR'(rr_pick(MAX_WR'(req), PTR_MAX_W'(rr_ptr), NUM_WR));
      ptr_next = rr_ptr;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if (gnt[i]) ptr_next = (i == NUM_WR - 1) ? '0 : PTR_W'(i + 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rr_ptr <= '0;
      else if (advance) rr_ptr <= ptr_next;
   end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Shares one single-command FIFO between NUM_WR writers and one reader, with
// write/read alternation under contention and a fixed-latency read return path.
module fifo_access_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_WR = 4,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   fifo_access_arbiter_if.slave    bus,
   output logic                    fifo_en,
   output logic                    fifo_wr_rd,
   output logic [DATA_W-1:0]       fifo_d_in,
   input  logic [DATA_W-1:0]       fifo_d_out,
   input  logic                    fifo_full,
   input  logic                    fifo_empty,
   input  logic                    stat_clr,
   output logic [CNT_W-1:0]        wr_count,
   output logic [CNT_W-1:0]        rd_count
);
   localparam int unsigned LAST = RD_LAT - 1;

   logic              write_elig;
   logic              read_elig;
   logic              do_write;
   logic              do_read;
   logic [NUM_WR-1:0] gnt;
   op_e               last_op;
   op_e               last_op_next;
   logic [RD_LAT-1:0] rd_pipe;
   logic [DATA_W-1:0] rd_hold;

   rr_arbiter #(.NUM_WR(NUM_WR)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.wr_valid),
      .advance (do_write),
      .gnt     (gnt)
   );

   // Operation select: a lone eligible side wins; under contention the side not served last wins.
   always_comb begin
      write_elig   = (|bus.wr_valid) & ~fifo_full;
      read_elig    = bus.rd_req & ~fifo_empty;
      do_write     = 1'b0;
      do_read      = 1'b0;
      last_op_next = last_op;
      if (write_elig && (!read_elig || (last_op == OP_READ))) begin
         do_write     = 1'b1;
         last_op_next = OP_WRITE;
      end else if (read_elig) begin
         do_read      = 1'b1;
         last_op_next = OP_READ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_op <= OP_READ;
      else     last_op <= last_op_next;
   end

   // FIFO command pins and handshakes follow the grant in the same cycle.
   always_comb begin
      bus.wr_ready = do_write ? gnt : '0;
      bus.rd_ready = do_read;
      fifo_en      = do_write | do_read;
      fifo_wr_rd   = do_write;
      fifo_d_in    = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if (do_write && gnt[i]) fifo_d_in = bus.wr_data[i*DATA_W +: DATA_W];
      end
   end

   // Read return pipe plus statistics; clear beats increment, counters stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe  <= '0;
         rd_hold  <= '0;
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         rd_pipe <= RD_LAT'({rd_pipe, do_read});
         if (rd_pipe[LAST]) rd_hold <= fifo_d_out;
         if (stat_clr)                        wr_count <= '0;
         else if (do_write && (wr_count != '1)) wr_count <= wr_count + CNT_W'(1);
         if (stat_clr)                        rd_count <= '0;
         else if (do_read && (rd_count != '1))  rd_count <= rd_count + CNT_W'(1);
      end
   end

   // Data is presented in the valid cycle itself and held afterwards.
   assign bus.rd_data_valid = rd_pipe[LAST];
   assign bus.rd_data       = rd_pipe[LAST] ? fifo_d_out : rd_hold;

endmodule
